button_conditioner: RTL

Input-side conditioner for the Millennium Clock push buttons: it sits between the raw board pins and the `Control` block. It synchronizes, debounces and edge-detects the four buttons (up, down, mode select, item select). It then emits single-cycle command pulses, with hold-to-repeat on the up/down buttons so fast time/date setting works. All outputs are in the 50 MHz domain, registered, and one `clk` cycle wide where pulsed.

---
 rtl/button_conditioner.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects four push buttons, producing one-cycle
// press/release pulses plus hold-to-repeat step pulses for the Control block.
module button_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 5000000,
   parameter logic [3:0]  REPEAT_MASK     = 4'b0011,
   parameter bit          ACTIVE_LOW      = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] btn_raw,
   output logic [3:0] btn_level,
   output logic [3:0] press_pulse,
   output logic [3:0] step_pulse,
   output logic [3:0] release_pulse
);

   localparam int unsigned MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
   localparam int unsigned MAX_CNT = (MAX_DR > REPEAT_RATE) ? MAX_DR : REPEAT_RATE;
   localparam int          CW      = $clog2(MAX_CNT + 1);

   localparam logic [CW-1:0] DC_TERM = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] RD_TERM = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] RR_TERM = CW'(REPEAT_RATE - 1);
   localparam logic [3:0]    RELEASED = {4{ACTIVE_LOW}};

   typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_e;

   logic [3:0]    sync1_q, sync1_d;
   logic [3:0]    sync2_q, sync2_d;
   logic [3:0]    level_q, level_d;
   logic [CW-1:0] dcnt_q [4];
   logic [CW-1:0] dcnt_d [4];
   logic [CW-1:0] rcnt_q [4];
   logic [CW-1:0] rcnt_d [4];
   state_e        state_q [4];
   state_e        state_d [4];
   logic [3:0]    press_q, press_d;
   logic [3:0]    step_q, step_d;
   logic [3:0]    release_q, release_d;

   logic [3:0]    sample;
   logic [3:0]    press_acc;
   logic [3:0]    release_acc;

   always_comb begin
      sync1_d     = btn_raw;
      sync2_d     = sync1_q;
      sample      = sync2_q ^ RELEASED;
      level_d     = level_q;
      dcnt_d      = dcnt_q;
      rcnt_d      = rcnt_q;
      state_d     = state_q;
      press_d     = '0;
      step_d      = '0;
      release_d   = '0;
      press_acc   = '0;
      release_acc = '0;

      for (int i = 0; i < 4; i++) begin
         // A level change is accepted only after DEBOUNCE_CYCLES consecutive differing samples.
         if (sample[i] == level_q[i]) begin
            dcnt_d[i] = '0;
         end else if (dcnt_q[i] == DC_TERM) begin
            level_d[i]     = ~level_q[i];
            dcnt_d[i]      = '0;
            press_acc[i]   = sample[i];
            release_acc[i] = ~sample[i];
         end else begin
            dcnt_d[i] = dcnt_q[i] + 1'b1;
         end

         // Release is checked before any due repeat so the release cycle never steps.
         case (state_q[i])
            IDLE: begin
               rcnt_d[i] = '0;
               if (press_acc[i]) begin
                  press_d[i] = 1'b1;
                  step_d[i]  = 1'b1;
                  state_d[i] = HOLD;
               end
            end
            HOLD: begin
               if (release_acc[i]) begin
                  release_d[i] = 1'b1;
                  rcnt_d[i]    = '0;
                  state_d[i]   = IDLE;
               end else if (!REPEAT_MASK[i]) begin
                  rcnt_d[i] = '0;
               end else if (rcnt_q[i] == RD_TERM) begin
                  step_d[i]  = 1'b1;
                  rcnt_d[i]  = '0;
                  state_d[i] = REPEAT;
               end else begin
                  rcnt_d[i] = rcnt_q[i] + 1'b1;
               end
            end
            REPEAT: begin
               if (release_acc[i]) begin
                  release_d[i] = 1'b1;
                  rcnt_d[i]    = '0;
                  state_d[i]   = IDLE;
               end else if (rcnt_q[i] == RR_TERM) begin
                  step_d[i] = 1'b1;
                  rcnt_d[i] = '0;
               end else begin
                  rcnt_d[i] = rcnt_q[i] + 1'b1;
               end
            end
            default: begin
               rcnt_d[i]  = '0;
               state_d[i] = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q   <= RELEASED;
         sync2_q   <= RELEASED;
         level_q   <= '0;
         press_q   <= '0;
         step_q    <= '0;
         release_q <= '0;
         for (int i = 0; i < 4; i++) begin
            dcnt_q[i]  <= '0;
            rcnt_q[i]  <= '0;
            state_q[i] <= IDLE;
         end
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         level_q   <= level_d;
         press_q   <= press_d;
         step_q    <= step_d;
         release_q <= release_d;
         for (int i = 0; i < 4; i++) begin
            dcnt_q[i]  <= dcnt_d[i];
            rcnt_q[i]  <= rcnt_d[i];
            state_q[i] <= state_d[i];
         end
      end
   end

   assign btn_level     = level_q;
   assign press_pulse   = press_q;
   assign step_pulse    = step_q;
   assign release_pulse = release_q;

endmodule
